imem_dmem_arbiter: RTL

IMEM_DMEM_ARBITER -- requirements
Module: imem_dmem_arbiter

---
 rtl/imem_dmem_arbiter_if.sv | 71 +++++++
 rtl/imem_dmem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// imem_dmem_arbiter_if
//
// Bundles the fetch-side request, data-side request, memory request/return
// and routed-response signals of the instruction/data memory arbiter.
//
// Modports:
//   slave  : the arbiter itself (takes requests and memory returns, drives
//            readies, tags, the memory command and routed responses).
//   master : the surrounding environment (caches + memory), the mirror image.
//
// Signal groups:
//   ic_req_*        fetch request (valid/addr in, ready/tag out)
//   dc_req_*        data request (valid/cmd/addr/data in, ready/tag out)
//   proc2mem_*      memory command/address/write data
//   mem2proc_*      memory accept tag, return data and return tag
//   ic/dc_resp_*    routed return (valid per side, shared tag/data)
//   err_unexp_tag   sticky flag for a return on an untracked tag
// ----------------------------------------------------------------------------
interface imem_dmem_arbiter_if;
    // Fetch side
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_req_ready;
    logic [3:0]  ic_req_tag;

    // Data side
    logic        dc_req_valid;
    logic [1:0]  dc_req_cmd;
    logic [31:0] dc_req_addr;
    logic [63:0] dc_req_data;
    logic        dc_req_ready;
    logic [3:0]  dc_req_tag;

    // Memory request
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;

    // Memory accept / return
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    // Routed return
    logic        ic_resp_valid;
    logic        dc_resp_valid;
    logic [3:0]  resp_tag;
    logic [63:0] resp_data;
    logic        err_unexp_tag;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_req_tag,
        input  dc_req_valid, dc_req_cmd, dc_req_addr, dc_req_data,
        output dc_req_ready, dc_req_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output ic_resp_valid, dc_resp_valid, resp_tag, resp_data, err_unexp_tag
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_req_tag,
        output dc_req_valid, dc_req_cmd, dc_req_addr, dc_req_data,
        input  dc_req_ready, dc_req_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  ic_resp_valid, dc_resp_valid, resp_tag, resp_data, err_unexp_tag
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// imem_dmem_arbiter
//
// Shares one tagged memory port between an instruction-fetch requester and a
// data requester. Arbitration is combinational; the memory accepts a request
// in the same cycle by returning a nonzero tag on mem2proc_response. Accepted
// loads are recorded in a 15-entry owner table (tags 1..15) so that later
// returns on mem2proc_tag can be routed back to the side that issued them.
//
// Ports:
//   clock  : clock
//   reset  : synchronous, active-high reset; all outputs are 0 while asserted
//   bus    : imem_dmem_arbiter_if.slave (request, memory and response signals)
//
// Configuration:
//   ARB_ROUND_ROBIN_EN  defined   -> on contention, grant the side that did not
//                                    win the last accepted request.
//                       undefined -> fixed priority, data over fetch.
// ----------------------------------------------------------------------------
module imem_dmem_arbiter (
    input  logic               clock,
    input  logic               reset,
    imem_dmem_arbiter_if.slave bus
);

    localparam logic [1:0] CmdNone  = 2'd0;
    localparam logic [1:0] CmdLoad  = 2'd1;
    localparam logic [1:0] CmdStore = 2'd2;

    typedef enum logic {
        GrantFetch = 1'b0,
        GrantData  = 1'b1
    } grant_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [15:1] tbl_valid_q, tbl_valid_d;
    logic [15:1] tbl_owner_q, tbl_owner_d;  // 0 = fetch, 1 = data
    logic        err_q, err_d;
    grant_e      last_grant_q, last_grant_d;

    // ------------------------------------------------------------------------
    // Request qualification and arbitration
    // ------------------------------------------------------------------------
    logic        ic_valid;
    logic        dc_valid;
    logic        any_valid;
    logic        grant_data;
    logic [1:0]  granted_cmd;
    logic [31:0] granted_addr;
    logic        mem_accept;
    logic        accept;
    logic        alloc;

    assign ic_valid  = bus.ic_req_valid;
    // Unknown data commands are dropped rather than forwarded to memory.
    assign dc_valid  = bus.dc_req_valid &&
                       ((bus.dc_req_cmd == CmdLoad) || (bus.dc_req_cmd == CmdStore));
    assign any_valid = ic_valid || dc_valid;

    always_comb begin
        grant_data = dc_valid;
        if (ic_valid && dc_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_data = (last_grant_q == GrantFetch);
`else
            grant_data = 1'b1;
`endif
        end
    end

    assign granted_cmd  = grant_data ? bus.dc_req_cmd  : CmdLoad;
    assign granted_addr = grant_data ? bus.dc_req_addr : bus.ic_req_addr;
    assign mem_accept   = (bus.mem2proc_response != 4'd0);
    assign accept       = !reset && any_valid && mem_accept;
    assign alloc        = accept && (granted_cmd == CmdLoad);

    // ------------------------------------------------------------------------
    // Memory request and per-side accept
    // ------------------------------------------------------------------------
    always_comb begin
        bus.proc2mem_command = CmdNone;
        bus.proc2mem_addr    = 32'd0;
        bus.proc2mem_data    = 64'd0;
        bus.ic_req_ready     = 1'b0;
        bus.ic_req_tag       = 4'd0;
        bus.dc_req_ready     = 1'b0;
        bus.dc_req_tag       = 4'd0;
        if (!reset && any_valid) begin
            bus.proc2mem_command = granted_cmd;
            bus.proc2mem_addr    = {granted_addr[31:3], 3'b000};
            if (grant_data && (granted_cmd == CmdStore)) begin
                bus.proc2mem_data = bus.dc_req_data;
            end
            if (mem_accept) begin
                if (grant_data) begin
                    bus.dc_req_ready = 1'b1;
                    bus.dc_req_tag   = bus.mem2proc_response;
                end else begin
                    bus.ic_req_ready = 1'b1;
                    bus.ic_req_tag   = bus.mem2proc_response;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Return routing
    // ------------------------------------------------------------------------
    logic ret_present;
    logic ret_hit;
    logic ret_unexp;

    assign ret_present = (bus.mem2proc_tag != 4'd0);
    // Lookup uses the pre-edge table so a same-cycle reallocation of this tag
    // still routes the return to its previous owner.
    assign ret_hit     = ret_present && tbl_valid_q[bus.mem2proc_tag];
    assign ret_unexp   = ret_present && !ret_hit;

    always_comb begin
        bus.ic_resp_valid = 1'b0;
        bus.dc_resp_valid = 1'b0;
        bus.resp_tag      = 4'd0;
        bus.resp_data     = 64'd0;
        if (!reset && ret_hit) begin
            if (tbl_owner_q[bus.mem2proc_tag]) begin
                bus.dc_resp_valid = 1'b1;
            end else begin
                bus.ic_resp_valid = 1'b1;
            end
            bus.resp_tag  = bus.mem2proc_tag;
            bus.resp_data = bus.mem2proc_data;
        end
    end

    // Flag is visible in the cycle the stray return arrives, then held.
    assign bus.err_unexp_tag = !reset && (err_q || ret_unexp);

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        tbl_valid_d  = tbl_valid_q;
        tbl_owner_d  = tbl_owner_q;
        err_d        = err_q;
        last_grant_d = last_grant_q;

        if (ret_hit) begin
            tbl_valid_d[bus.mem2proc_tag] = 1'b0;
        end
        if (ret_unexp) begin
            err_d = 1'b1;
        end
        if (accept) begin
            last_grant_d = grant_data ? GrantData : GrantFetch;
        end
        // Applied after the clear so a same-tag accept leaves the new owner.
        if (alloc) begin
            tbl_valid_d[bus.mem2proc_response] = 1'b1;
            tbl_owner_d[bus.mem2proc_response] = grant_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tbl_valid_q  <= '0;
            tbl_owner_q  <= '0;
            err_q        <= 1'b0;
            last_grant_q <= GrantFetch;
        end else begin
            tbl_valid_q  <= tbl_valid_d;
            tbl_owner_q  <= tbl_owner_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
